execute_stage_pipe: RTL and testbench

- Registered, parametrised successor to the combinational execute stage of the MIPS-lite 5-stage pipeline; sits between ID/EX and EX/MEM.
- Adds a valid/ready handshake on both sides.
- Adds a multi-cycle signed multiplier with a busy FSM, a flush input for branch squash, and address-overflow reporting.
- All outputs form the EX/MEM register.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/execute_stage_pipe_mul.sv | 81 ++++++++
 rtl/execute_stage_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_execute_stage_pipe.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS-lite execute stage: control bundle, ALU opcodes, unit state.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 32;
    localparam int MIPS_DEST_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_MUL  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_AND  = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_BEQZ = 3'b110,
        ALU_BEQ  = 3'b111
    } alu_op_e;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } exec_state_e;

    typedef struct packed {
        logic [2:0]             alu_op;
        logic                   src_reg2;
        logic                   jump;
        logic                   reg_write;
        logic [MIPS_DEST_W-1:0] dest;
    } ctrl_t;

endpackage

// File: rtl/execute_stage_pipe_mul.sv
// Multi-cycle signed multiplier for the execute stage: operand capture, busy FSM, countdown, done pulse.
// With MIPS_EXEC_OVF_TRAP_EN defined it also reports when the product does not fit in DATA signed bits.
module exec_mul_unit
    import mips_pkg::*;
#(
    parameter int DATA       = MIPS_DATA_W,
    parameter int MUL_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start_i,
    input  logic [DATA-1:0] a_i,
    input  logic [DATA-1:0] b_i,
    input  logic            out_free_i,
    output logic            busy_o,
    output logic            done_o,
`ifdef MIPS_EXEC_OVF_TRAP_EN
    output logic            ovf_o,
`endif
    output logic [DATA-1:0] product_o
);

    localparam int              CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 2);
    localparam logic [0:0]      S_IDLE   = IDLE;
    localparam logic [0:0]      S_BUSY   = MUL_BUSY;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [DATA-1:0] a_q, b_q;

    assign busy_o = (state_q == S_BUSY);
    // Completion waits at count zero until the output register can take the product.
    assign done_o = busy_o && (cnt_q == '0) && out_free_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (start_i) begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
        end else if (busy_o) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (out_free_i) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

`ifdef MIPS_EXEC_OVF_TRAP_EN
    logic [2*DATA-1:0] full_prod;
    assign full_prod = {{DATA{a_q[DATA-1]}}, a_q} * {{DATA{b_q[DATA-1]}}, b_q};
    assign product_o = full_prod[DATA-1:0];
    assign ovf_o     = !((&full_prod[2*DATA-1:DATA-1]) || !(|full_prod[2*DATA-1:DATA-1]));
`else
    assign product_o = a_q * b_q;
`endif

endmodule

// File: rtl/execute_stage_pipe.sv
// Registered MIPS-lite execute stage with valid/ready handshake, multi-cycle MUL and flush.
// Optional MIPS_EXEC_OVF_TRAP_EN adds ovf_trap and suppresses writeback on arithmetic overflow.
module execute_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA       = MIPS_DATA_W,
    parameter int ADDR_W     = MIPS_ADDR_W,
    parameter int MUL_CYCLES = 4,
    parameter int DEST_W     = MIPS_DEST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA-1:0]   read_data_1,
    input  logic [DATA-1:0]   read_data_2,
    input  logic [DATA-1:0]   imm_data,
    input  logic [ADDR_W-1:0] pc_plus_4,
    input  ctrl_t             cntrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA-1:0]   alu_o,
    output logic [DATA-1:0]   write_data,
    output logic [ADDR_W-1:0] new_addr,
    output logic              is_taken,
    output logic              addr_err,
    output logic [DEST_W-1:0] dest_o,
`ifdef MIPS_EXEC_OVF_TRAP_EN
    output logic              ovf_trap,
`endif
    output logic              reg_write_o
);

    logic signed [DATA-1:0]   op_a, op_b, sum, diff;
    logic [DATA-1:0]          alu_res, mul_prod;
    logic                     alu_taken;
    logic signed [ADDR_W-1:0] pc_s, off_s;
    logic signed [ADDR_W:0]   tgt_sum;
    logic [ADDR_W-1:0]        tgt;
    logic                     tgt_err;
    logic                     busy, mul_done, out_free, accept, is_mul, mul_start;

    logic                     vld_q, vld_d, taken_q, taken_d, err_q, err_d, rw_q, rw_d;
    logic [DATA-1:0]          alu_q, alu_d, wd_q, wd_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DEST_W-1:0]        dest_q, dest_d;

    logic [DATA-1:0]          pend_wd_q;
    logic [ADDR_W-1:0]        pend_addr_q;
    logic                     pend_err_q, pend_rw_q;
    logic [DEST_W-1:0]        pend_dest_q;

`ifdef MIPS_EXEC_OVF_TRAP_EN
    logic alu_ovf, mul_ovf, trap_q, trap_d;
`endif

    assign op_a = read_data_1;
    assign op_b = cntrl.src_reg2 ? read_data_2 : imm_data;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        alu_res   = '0;
        alu_taken = 1'b0;
        case (alu_op_e'(cntrl.alu_op))
            ALU_ADD: begin
                alu_res   = sum;
                alu_taken = cntrl.jump;
            end
            ALU_SUB:  alu_res = diff;
            ALU_MUL:  alu_res = '0;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_BEQZ: begin
                alu_taken = (op_a == '0);
                alu_res   = {{(DATA-1){1'b0}}, alu_taken};
            end
            ALU_BEQ: begin
                alu_taken = (op_a == op_b);
                alu_res   = {{(DATA-1){1'b0}}, alu_taken};
            end
            default: alu_res = '0;
        endcase
    end

`ifdef MIPS_EXEC_OVF_TRAP_EN
    always_comb begin
        alu_ovf = 1'b0;
        if (alu_op_e'(cntrl.alu_op) == ALU_ADD) begin
            alu_ovf = (op_a[DATA-1] == op_b[DATA-1]) && (sum[DATA-1] != op_a[DATA-1]);
        end else if (alu_op_e'(cntrl.alu_op) == ALU_SUB) begin
            alu_ovf = (op_a[DATA-1] != op_b[DATA-1]) && (diff[DATA-1] != op_a[DATA-1]);
        end
    end
`endif

    // Branch target is summed one bit wider so signed overflow shows up as a sign disagreement.
    assign pc_s    = pc_plus_4;
    assign off_s   = imm_data[ADDR_W-1:0] << 2;
    assign tgt_sum = {pc_s[ADDR_W-1], pc_s} + {off_s[ADDR_W-1], off_s};
    assign tgt     = cntrl.jump ? read_data_1[ADDR_W-1:0] : tgt_sum[ADDR_W-1:0];
    assign tgt_err = !cntrl.jump && (tgt_sum[ADDR_W] != tgt_sum[ADDR_W-1]);

    assign out_free  = !vld_q || out_ready;
    assign in_ready  = !busy && out_free && !flush;
    assign accept    = in_valid && in_ready;
    assign is_mul    = (alu_op_e'(cntrl.alu_op) == ALU_MUL);
    assign mul_start = accept && is_mul;

    exec_mul_unit #(
        .DATA       (DATA),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .start_i    (mul_start),
        .a_i        (op_a),
        .b_i        (op_b),
        .out_free_i (out_free),
        .busy_o     (busy),
        .done_o     (mul_done),
`ifdef MIPS_EXEC_OVF_TRAP_EN
        .ovf_o      (mul_ovf),
`endif
        .product_o  (mul_prod)
    );

    // Side-band fields of a MUL travel with it until the product is ready.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            pend_wd_q   <= read_data_2;
            pend_addr_q <= tgt;
            pend_err_q  <= tgt_err;
            pend_rw_q   <= cntrl.reg_write;
            pend_dest_q <= DEST_W'(cntrl.dest);
        end
    end

    always_comb begin
        vld_d   = vld_q;
        alu_d   = alu_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        taken_d = taken_q;
        err_d   = err_q;
        dest_d  = dest_q;
        rw_d    = rw_q;
`ifdef MIPS_EXEC_OVF_TRAP_EN
        trap_d  = trap_q;
`endif
        if (flush) begin
            vld_d = 1'b0;
        end else if (mul_done) begin
            vld_d   = 1'b1;
            alu_d   = mul_prod;
            wd_d    = pend_wd_q;
            addr_d  = pend_addr_q;
            taken_d = 1'b0;
            err_d   = pend_err_q;
            dest_d  = pend_dest_q;
`ifdef MIPS_EXEC_OVF_TRAP_EN
            rw_d    = pend_rw_q && !mul_ovf;
            trap_d  = mul_ovf;
`else
            rw_d    = pend_rw_q;
`endif
        end else if (accept && !is_mul) begin
            vld_d   = 1'b1;
            alu_d   = alu_res;
            wd_d    = read_data_2;
            addr_d  = tgt;
            taken_d = alu_taken;
            err_d   = tgt_err;
            dest_d  = DEST_W'(cntrl.dest);
`ifdef MIPS_EXEC_OVF_TRAP_EN
            rw_d    = cntrl.reg_write && !alu_ovf;
            trap_d  = alu_ovf;
`else
            rw_d    = cntrl.reg_write;
`endif
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    // EX/MEM register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            alu_q   <= '0;
            wd_q    <= '0;
            addr_q  <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
            dest_q  <= '0;
            rw_q    <= 1'b0;
`ifdef MIPS_EXEC_OVF_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            vld_q   <= vld_d;
            alu_q   <= alu_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            taken_q <= taken_d;
            err_q   <= err_d;
            dest_q  <= dest_d;
            rw_q    <= rw_d;
`ifdef MIPS_EXEC_OVF_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    assign out_valid   = vld_q;
    assign alu_o       = alu_q;
    assign write_data  = wd_q;
    assign new_addr    = addr_q;
    assign is_taken    = taken_q;
    assign addr_err    = err_q;
    assign dest_o      = dest_q;
    assign reg_write_o = rw_q;
`ifdef MIPS_EXEC_OVF_TRAP_EN
    assign ovf_trap    = trap_q;
`endif

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Scoreboard bench for execute_stage_pipe: directed scenarios plus a randomized handshake stream.
module tb_execute_stage_pipe;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] addr;
        logic        taken;
        logic        err;
        logic [4:0]  dest;
        logic        rw;
        logic        trap;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic        is_taken, addr_err, reg_write_o;
    logic [31:0] read_data_1, read_data_2, imm_data, pc_plus_4;
    logic [31:0] alu_o, write_data, new_addr;
    logic [4:0]  dest_o;
    ctrl_t       cntrl;
`ifdef MIPS_EXEC_OVF_TRAP_EN
    logic        ovf_trap;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    execute_stage_pipe #(
        .DATA       (32),
        .ADDR_W     (32),
        .MUL_CYCLES (4),
        .DEST_W     (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .imm_data    (imm_data),
        .pc_plus_4   (pc_plus_4),
        .cntrl       (cntrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_o       (alu_o),
        .write_data  (write_data),
        .new_addr    (new_addr),
        .is_taken    (is_taken),
        .addr_err    (addr_err),
        .dest_o      (dest_o),
`ifdef MIPS_EXEC_OVF_TRAP_EN
        .ovf_trap    (ovf_trap),
`endif
        .reg_write_o (reg_write_o)
    );

    function automatic exp_t model(input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input ctrl_t c);
        exp_t        e;
        logic [31:0] b;
        longint      sa, sbv, r, tgt;
        logic        ovf;
        logic [31:0] off;
        e   = '0;
        ovf = 1'b0;
        b   = c.src_reg2 ? rt : imm;
        sa  = longint'($signed(rs));
        sbv = longint'($signed(b));
        e.wd   = rt;
        e.dest = c.dest;
        case (c.alu_op)
            3'd0: begin r = sa + sbv; e.alu = r[31:0]; e.taken = c.jump; ovf = (r > SMAX) || (r < SMIN); end
            3'd1: begin r = sa - sbv; e.alu = r[31:0]; ovf = (r > SMAX) || (r < SMIN); end
            3'd2: begin r = sa * sbv; e.alu = r[31:0]; ovf = (r > SMAX) || (r < SMIN); end
            3'd3: e.alu = rs | b;
            3'd4: e.alu = rs & b;
            3'd5: e.alu = rs ^ b;
            3'd6: begin e.taken = (rs == 32'd0); e.alu = {31'd0, e.taken}; end
            default: begin e.taken = (rs == b); e.alu = {31'd0, e.taken}; end
        endcase
        off = imm << 2;
        tgt = longint'($signed(pc)) + longint'($signed(off));
        if (c.jump) begin
            e.addr = rs;
        end else begin
            e.addr = tgt[31:0];
            e.err  = (tgt > SMAX) || (tgt < SMIN);
        end
`ifdef MIPS_EXEC_OVF_TRAP_EN
        e.trap = ovf;
        e.rw   = c.reg_write && !ovf;
`else
        e.rw   = c.reg_write;
`endif
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.alu   = alu_o;
        o.wd    = write_data;
        o.addr  = new_addr;
        o.taken = is_taken;
        o.err   = addr_err;
        o.dest  = dest_o;
        o.rw    = reg_write_o;
`ifdef MIPS_EXEC_OVF_TRAP_EN
        o.trap  = ovf_trap;
`else
        o.trap  = 1'b0;
`endif
        return o;
    endfunction

    // Scoreboard: every drained entry is checked; flush/reset discard anything not yet drained.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected got=%h required=<no entry>", observed());
                end else begin
                    exp_t e;
                    exp_t o;
                    e = sb.pop_front();
                    o = observed();
                    if (o !== e) begin
                        n_errors++;
                        $display("FAIL sb_entry got=%h required=%h", o, e);
                    end
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back(model(read_data_1, read_data_2, imm_data, pc_plus_4, cntrl));
            end
        end
    end

    task automatic set_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] imm, input logic [31:0] pc, input logic src,
                          input logic jmp, input logic rw, input logic [4:0] d);
        read_data_1     = rs;
        read_data_2     = rt;
        imm_data        = imm;
        pc_plus_4       = pc;
        cntrl.alu_op    = op;
        cntrl.src_reg2  = src;
        cntrl.jump      = jmp;
        cntrl.reg_write = rw;
        cntrl.dest      = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, alu_o, write_data, new_addr, is_taken, addr_err, dest_o, reg_write_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got vld=%b alu=%h addr=%h rw=%b required all zero",
                     out_valid, alu_o, new_addr, reg_write_o);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
    endtask

    task automatic test_add();
        @(posedge clk); #1;
        set_op(3'd0, 32'd5, 32'h0000_00AA, 32'hFFFF_FFF9, 32'h40, 1'b0, 1'b0, 1'b1, 5'd3);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || alu_o !== 32'hFFFF_FFFE || is_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL add_result got vld=%b alu=%h taken=%b required vld=1 alu=fffffffe taken=0",
                     out_valid, alu_o, is_taken);
        end
    endtask

    task automatic test_beq();
        @(posedge clk); #1;
        set_op(3'd7, 32'h1234, 32'h1234, 32'd3, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0);
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (is_taken !== 1'b1 || new_addr !== 32'h10C || addr_err !== 1'b0 || alu_o !== 32'd1) begin
            n_errors++;
            $display("FAIL beq_taken got taken=%b addr=%h err=%b alu=%h required 1 0000010c 0 00000001",
                     is_taken, new_addr, addr_err, alu_o);
        end
    endtask

    task automatic test_mul();
        @(posedge clk); #1;
        set_op(3'd2, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'h200, 1'b1, 1'b0, 1'b1, 5'd9);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL mul_busy cycle %0d got ready=%b vld=%b required ready=0 vld=0",
                         i + 1, in_ready, out_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || alu_o !== 32'hFFFF_FFEB) begin
            n_errors++;
            $display("FAIL mul_result got vld=%b alu=%h required vld=1 alu=ffffffeb", out_valid, alu_o);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        set_op(3'd2, 32'd100, 32'hFFFF_FFFE, 32'd0, 32'h300, 1'b1, 1'b0, 1'b1, 5'd4);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || alu_o !== 32'hFFFF_FF38) begin
            n_errors++;
            $display("FAIL bp_mul_result got vld=%b alu=%h required vld=1 alu=ffffff38", out_valid, alu_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || alu_o !== 32'hFFFF_FF38 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold got vld=%b alu=%h ready=%b required vld=1 alu=ffffff38 ready=0",
                         out_valid, alu_o, in_ready);
            end
        end
        @(posedge clk); #1;
        set_op(3'd0, 32'd10, 32'd0, 32'd20, 32'h400, 1'b0, 1'b0, 1'b1, 5'd6);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_drain_accept got ready=%b required=1", in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || alu_o !== 32'd30) begin
            n_errors++;
            $display("FAIL bp_next_add got vld=%b alu=%h required vld=1 alu=0000001e", out_valid, alu_o);
        end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        set_op(3'd2, 32'd9, 32'd9, 32'd0, 32'h500, 1'b1, 1'b0, 1'b1, 5'd7);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        set_op(3'd0, 32'd1, 32'd0, 32'd1, 32'h600, 1'b0, 1'b0, 1'b1, 5'd8);
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_blocks_accept got ready=%b required=0", in_ready);
        end
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_idle got vld=%b ready=%b required vld=0 ready=1", out_valid, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL flush_discard cycle %0d got vld=%b required=0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        @(posedge clk); #1;
        set_op(3'd2, 32'd6, 32'd7, 32'd0, 32'h700, 1'b1, 1'b0, 1'b1, 5'd2);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, alu_o, write_data, new_addr, dest_o, reg_write_o} !== '0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_mul got vld=%b alu=%h wd=%h ready=%b required zeros and ready=1",
                     out_valid, alu_o, write_data, in_ready);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mul_discard got vld=%b required=0", out_valid);
        end
    endtask

    task automatic test_addr_ovf();
        @(posedge clk); #1;
        set_op(3'd0, 32'd0, 32'd0, 32'd1, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b1, 5'd1);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        set_op(3'd0, 32'h0040_0000, 32'd0, 32'd1, 32'h7FFF_FFFC, 1'b0, 1'b1, 1'b0, 5'd1);
        @(negedge clk);
        n_checks++;
        if (addr_err !== 1'b1 || new_addr !== 32'h8000_0000) begin
            n_errors++;
            $display("FAIL target_ovf got err=%b addr=%h required err=1 addr=80000000", addr_err, new_addr);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (addr_err !== 1'b0 || new_addr !== 32'h0040_0000 || is_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL jump_target got err=%b addr=%h taken=%b required 0 00400000 1",
                     addr_err, new_addr, is_taken);
        end
    endtask

    task automatic test_ovf_trap();
        @(posedge clk); #1;
        set_op(3'd0, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'h100, 1'b0, 1'b0, 1'b1, 5'd5);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
`ifdef MIPS_EXEC_OVF_TRAP_EN
        if (alu_o !== 32'h8000_0000 || ovf_trap !== 1'b1 || reg_write_o !== 1'b0) begin
            n_errors++;
            $display("FAIL add_trap got alu=%h trap=%b rw=%b required 80000000 1 0", alu_o, ovf_trap, reg_write_o);
        end
`else
        if (alu_o !== 32'h8000_0000 || reg_write_o !== 1'b1) begin
            n_errors++;
            $display("FAIL add_wrap got alu=%h rw=%b required 80000000 1", alu_o, reg_write_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] rs, rt, imm;
        int waited;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = $urandom_range(0, 200) - 100;
                2:       rs = $urandom;
                default: rs = 32'h7FFF_FFF0 + $urandom_range(0, 31);
            endcase
            rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 64) - 32 : $urandom;
            set_op(3'($urandom_range(0, 7)), rs, rt, imm, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_timeout got pending=%0d vld=%b required pending=0 vld=0", sb.size(), out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_beq();
        test_mul();
        test_backpressure();
        test_flush();
        test_reset_mid_mul();
        test_addr_ovf();
        test_ovf_trap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
